// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
// ---------------------------------------------------------------------------
// Initiator-side controller for a single-port SRAM wrapper with a
// combinational read path and a clock-edge write.
//
// Clients issue reads and writes over a valid/ready request channel. Read
// data comes back one cycle later over a single-entry valid/ready response
// channel. The controller also owns a clear engine. When that engine is
// enabled, it writes INITIAL_VALUE to every SRAM word after reset and
// whenever a clear is requested.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_wren                1 = write, 0 = read
//   i_req_addr, i_req_wdata   request address / write data
//   o_rsp_valid/i_rsp_ready   read-response handshake
//   o_rsp_rdata               read data, held while the response is stalled
//   i_clear                   start a full clear (sampled only while idle)
//   o_clear_busy              clear engine is sweeping the array
//   o_clear_done              one-cycle pulse on the first idle cycle after a clear
//   o_sram_cs/wren/addr/din   SRAM pins driven by the controller
//   i_sram_dout               SRAM read data (valid in the same cycle as addr)
// ---------------------------------------------------------------------------
module sram_req_ctrl #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    SRAM_DEPTH    = 128,
    parameter int                    ADDR_WIDTH    = $clog2(SRAM_DEPTH),
    parameter bit                    CLEAR_ENABLE  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wren,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,

    input  logic                  i_clear,
    output logic                  o_clear_busy,
    output logic                  o_clear_done,

    output logic                  o_sram_cs,
    output logic                  o_sram_wren,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    clear_done_reg, clear_done_next;

    logic                    req_ready;
    logic                    clear_req;
    logic                    accept;
    logic                    rsp_drain;
    logic                    sram_cs;
    logic                    sram_wren;
    logic [ADDR_WIDTH-1:0]   sram_addr;
    logic [DATA_WIDTH-1:0]   sram_din;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= CLEAR_ENABLE ? ST_CLEAR : ST_IDLE;
            clr_cnt_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clr_cnt_reg    <= clr_cnt_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            clear_done_reg <= clear_done_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next      = state_reg;
        clr_cnt_next    = clr_cnt_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_rdata_next  = rsp_rdata_reg;
        clear_done_next = 1'b0;
        req_ready       = 1'b0;
        clear_req       = 1'b0;
        accept          = 1'b0;
        sram_cs         = 1'b0;
        sram_wren       = 1'b0;
        sram_addr       = '0;
        sram_din        = '0;

        // The response register drains independently of the state, so a
        // held response can be consumed while a clear is sweeping the array.
        rsp_drain = rsp_valid_reg & i_rsp_ready;

        case (state_reg)
            ST_CLEAR: begin
                sram_cs      = 1'b1;
                sram_wren    = 1'b1;
                sram_addr    = clr_cnt_reg;
                sram_din     = INITIAL_VALUE;
                clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next      = ST_IDLE;
                    clr_cnt_next    = '0;
                    clear_done_next = 1'b1;
                end
                if (rsp_drain) begin
                    rsp_valid_next = 1'b0;
                end
            end

            ST_IDLE: begin
                clear_req = i_clear & CLEAR_ENABLE;
                // A new read may be accepted when the response slot is empty
                // or is being emptied this cycle.
                req_ready = ~clear_req & (~rsp_valid_reg | i_rsp_ready);
                accept    = i_req_valid & req_ready;
                if (accept) begin
                    sram_cs   = 1'b1;
                    sram_wren = i_req_wren;
                    sram_addr = i_req_addr;
                    sram_din  = i_req_wdata;
                end
                // If a new read and a drain happen in the same cycle, the new
                // read wins. The slot is reloaded and valid stays high.
                if (accept & ~i_req_wren) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = i_sram_dout;
                end else if (rsp_drain) begin
                    rsp_valid_next = 1'b0;
                end
                if (clear_req) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_req_ready  = req_ready;
    assign o_rsp_valid  = rsp_valid_reg;
    assign o_rsp_rdata  = rsp_rdata_reg;
    assign o_clear_busy = (state_reg == ST_CLEAR);
    assign o_clear_done = clear_done_reg;
    assign o_sram_cs    = sram_cs;
    assign o_sram_wren  = sram_wren;
    assign o_sram_addr  = sram_addr;
    assign o_sram_din   = sram_din;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl
// Bench for sram_req_ctrl with DEPTH=8, DW=8 and INITIAL_VALUE=A5.
// Instance dut is built with the clear engine enabled; instance dut0 is
// built with it disabled. Each instance drives a small SRAM model in this
// file. A behavioural reference model is compared against dut on every
// cycle, and directed literal checks pin the scenarios from the test plan.
module tb_sram_req_ctrl;
    localparam int         DW    = 8;
    localparam int         DEPTH = 8;
    localparam int         AW    = 3;
    localparam logic [7:0] INIT  = 8'hA5;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut (clear enabled) ----------------
    logic          rst, req_valid, req_ready, req_wren, rsp_valid, rsp_ready;
    logic [AW-1:0] req_addr, sram_addr;
    logic [DW-1:0] req_wdata, rsp_rdata, sram_din, sram_dout;
    logic          clear, clear_busy, clear_done, sram_cs, sram_wren;

    sram_req_ctrl #(.DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .CLEAR_ENABLE(1'b1), .INITIAL_VALUE(INIT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wren(req_wren),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .i_clear(clear), .o_clear_busy(clear_busy), .o_clear_done(clear_done),
        .o_sram_cs(sram_cs), .o_sram_wren(sram_wren), .o_sram_addr(sram_addr),
        .o_sram_din(sram_din), .i_sram_dout(sram_dout));

    logic [DW-1:0] sram_mem [DEPTH];
    assign sram_dout = sram_mem[sram_addr];
    always_ff @(posedge clk) if (sram_cs && sram_wren) sram_mem[sram_addr] <= sram_din;

    // ---------------- dut0 (clear disabled) ----------------
    logic          z_rst, z_req_valid, z_req_ready, z_req_wren, z_rsp_valid, z_rsp_ready;
    logic [AW-1:0] z_req_addr, z_sram_addr;
    logic [DW-1:0] z_req_wdata, z_rsp_rdata, z_sram_din, z_sram_dout;
    logic          z_clear, z_clear_busy, z_clear_done, z_sram_cs, z_sram_wren;

    sram_req_ctrl #(.DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .CLEAR_ENABLE(1'b0), .INITIAL_VALUE(INIT)) dut0 (
        .clk(clk), .rst(z_rst),
        .i_req_valid(z_req_valid), .o_req_ready(z_req_ready), .i_req_wren(z_req_wren),
        .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready), .o_rsp_rdata(z_rsp_rdata),
        .i_clear(z_clear), .o_clear_busy(z_clear_busy), .o_clear_done(z_clear_done),
        .o_sram_cs(z_sram_cs), .o_sram_wren(z_sram_wren), .o_sram_addr(z_sram_addr),
        .o_sram_din(z_sram_din), .i_sram_dout(z_sram_dout));

    logic [DW-1:0] z_sram_mem [DEPTH];
    assign z_sram_dout = z_sram_mem[z_sram_addr];
    always_ff @(posedge clk) if (z_sram_cs && z_sram_wren) z_sram_mem[z_sram_addr] <= z_sram_din;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model. It tracks how many words remain to be cleared, the
    // pending response as a queue holding at most one entry, and the
    // expected memory contents.
    bit            model_ok = 0;
    bit            clearing;
    int            clear_left;
    bit            done_exp;
    logic [DW-1:0] rsp_q [$];
    logic [DW-1:0] rdata_hold;
    logic [DW-1:0] mem_m [DEPTH];

    initial begin
        bit            e_ready, acc, e_cs, e_wren;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                e_ready = !clearing && !clear && (rsp_q.size() == 0 || rsp_ready);
                acc     = req_valid && e_ready;
                if (clearing) begin
                    e_cs = 1; e_wren = 1; e_addr = AW'(DEPTH - clear_left); e_din = INIT;
                end else if (acc) begin
                    e_cs = 1; e_wren = req_wren; e_addr = req_addr; e_din = req_wdata;
                end else begin
                    e_cs = 0; e_wren = 0; e_addr = '0; e_din = '0;
                end
                chk("m_busy", clear_busy, clearing);
                chk("m_done", clear_done, done_exp);
                chk("m_req_ready", req_ready, e_ready);
                chk("m_rsp_valid", rsp_valid, rsp_q.size() != 0);
                chk("m_rsp_rdata", rsp_rdata, rdata_hold);
                chk("m_sram_cs", sram_cs, e_cs);
                chk("m_sram_wren", sram_wren, e_wren);
                chk("m_sram_addr", sram_addr, e_addr);
                chk("m_sram_din", sram_din, e_din);
                if (acc)
                    $display("txn %s addr=%0d wdata=%h", req_wren ? "WR" : "RD", req_addr, req_wdata);
                if (e_cs && e_wren) mem_m[e_addr] = e_din;
                if (rst) begin
                    clearing = 1; clear_left = DEPTH; done_exp = 0;
                    rsp_q.delete(); rdata_hold = '0;
                end else begin
                    done_exp = 0;
                    if (rsp_q.size() != 0 && rsp_ready) void'(rsp_q.pop_front());
                    if (clearing) begin
                        clear_left--;
                        if (clear_left == 0) begin clearing = 0; done_exp = 1; end
                    end else begin
                        if (acc && !req_wren) begin
                            rsp_q.push_back(mem_m[req_addr]);
                            rdata_hold = mem_m[req_addr];
                        end
                        if (clear) begin clearing = 1; clear_left = DEPTH; end
                    end
                end
            end else if (rst) begin
                clearing = 1; clear_left = DEPTH; done_exp = 0;
                rsp_q.delete(); rdata_hold = '0; model_ok = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input bit w, input int a, input logic [7:0] d, output int waits);
        req_valid = 1; req_wren = w; req_addr = AW'(a); req_wdata = d;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 40) begin
                chk("req_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic read_chk(input int a, input logic [7:0] e, input string nm);
        int w;
        do_req(0, a, 8'h00, w);
        @(negedge clk);
        chk({nm, "_valid"}, rsp_valid, 1);
        chk({nm, "_data"}, rsp_rdata, e);
        @(posedge clk); #1;
    endtask

    task automatic count_clear(output int busy_n, output int done_n);
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (clear_busy) busy_n++;
            if (clear_done) done_n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bn, dn;
        rst = 1; req_valid = 0; req_wren = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1; clear = 0;
        z_rst = 1; z_req_valid = 0; z_req_wren = 0; z_req_addr = '0; z_req_wdata = '0;
        z_rsp_ready = 1; z_clear = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_clear_busy", clear_busy, 1);
        chk("rst_sram_addr", sram_addr, 0);
        @(posedge clk); #1;
        rst = 0;

        // 1. reset clear
        count_clear(bn, dn);
        chk("t1_busy_cycles", bn, 8);
        chk("t1_done_pulses", dn, 1);
        for (int a = 0; a < DEPTH; a++) read_chk(a, INIT, "t1_read");

        // 2. back-to-back write then read of the same address
        do_req(1, 5, 8'h3C, w);
        do_req(0, 5, 8'h00, w);
        chk("t2_read_no_wait", w, 0);
        @(negedge clk);
        chk("t2_valid", rsp_valid, 1);
        chk("t2_data", rsp_rdata, 8'h3C);
        @(posedge clk); #1;

        // 3. backpressure with a same-cycle reload
        do_req(1, 2, 8'h11, w);
        rsp_ready = 0;
        do_req(0, 2, 8'h00, w);
        req_valid = 1; req_wren = 0; req_addr = 3'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_ready_low", req_ready, 0);
            chk("t3_data_stable", rsp_rdata, 8'h11);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("t3_ready_drain", req_ready, 1);
        chk("t3_data_drain", rsp_rdata, 8'h11);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk("t3_reload_valid", rsp_valid, 1);
        chk("t3_reload_data", rsp_rdata, 8'h3C);
        @(posedge clk); #1;

        // 4. on-demand clear while a response is held
        rsp_ready = 0;
        do_req(0, 1, 8'h00, w);
        clear = 1; req_valid = 1; req_wren = 1; req_addr = 3'd0; req_wdata = 8'h77;
        @(negedge clk);
        chk("t4_no_accept", req_ready, 0);
        chk("t4_no_cs", sram_cs, 0);
        @(posedge clk); #1;
        clear = 0; req_valid = 0;
        bn = 0; dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (clear_busy) bn++;
            if (clear_done) dn++;
            if (i == 3) begin
                chk("t4_held_valid", rsp_valid, 1);
                chk("t4_held_data", rsp_rdata, INIT);
            end
            if (i == 4) chk("t4_drained", rsp_valid, 0);
            @(posedge clk); #1;
            if (i == 2) rsp_ready = 1;
        end
        chk("t4_busy_cycles", bn, 8);
        chk("t4_done_pulses", dn, 1);
        for (int a = 0; a < DEPTH; a++) read_chk(a, INIT, "t4_read");

        // 5. reset in the middle of a clear
        rsp_ready = 0;
        do_req(1, 6, 8'h42, w);
        do_req(0, 6, 8'h00, w);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("t5_addr_restart", sram_addr, 0);
        chk("t5_rsp_discarded", rsp_valid, 0);
        @(posedge clk); #1;
        count_clear(bn, dn);
        chk("t5_busy_cycles", bn, 7);
        chk("t5_done_pulses", dn, 1);
        rsp_ready = 1;

        // randomized traffic, compared against the model every cycle
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_wren  = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            req_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        req_valid = 0; clear = 0; rsp_ready = 1;
        repeat (12) begin @(posedge clk); #1; end

        // 6. build with the clear engine disabled
        z_clear = 1;
        z_rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_busy", z_clear_busy, 0);
            chk("t6_done", z_clear_done, 0);
            chk("t6_ready", z_req_ready, 1);
            chk("t6_no_write", z_sram_cs, 0);
            @(posedge clk); #1;
        end
        z_req_valid = 1; z_req_wren = 1; z_req_addr = 3'd3; z_req_wdata = 8'h5A;
        @(negedge clk);
        chk("t6_wr_cs", z_sram_cs, 1);
        chk("t6_wr_wren", z_sram_wren, 1);
        @(posedge clk); #1;
        z_req_wren = 0;
        @(negedge clk);
        chk("t6_rd_ready", z_req_ready, 1);
        @(posedge clk); #1;
        z_req_valid = 0;
        @(negedge clk);
        chk("t6_rd_valid", z_rsp_valid, 1);
        chk("t6_rd_data", z_rsp_rdata, 8'h5A);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
